// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss refill: stalls fetch, reads the four 16-bit words of the
// missing 64-bit line over a req/ack handshake, then writes the line to the cache.
module icache_refill_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int LINE_WORDS  = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_en,
  input  logic [ADDR_W-1:0]        pc_addr,
  input  logic                     cache_hit,
  output logic                     stall,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_ack,
  input  logic [15:0]              mem_rdata,
  output logic                     fill_valid,
  output logic [ADDR_W-1:0]        fill_addr,
  output logic [16*LINE_WORDS-1:0] fill_data,
  output logic                     mem_err
);

  localparam int LINE_W = 16 * LINE_WORDS;
  localparam int TW     = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, FETCH, FILL, SETTLE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [1:0]        k;
  logic [TW-1:0]     tmo_cnt;
  logic [LINE_W-1:0] line;
  logic              miss;

  assign miss  = fetch_en & ~cache_hit;
  assign stall = (state == IDLE) ? miss : 1'b1;

  // Assembly buffer holds only data; a reset mid-refill is discarded because k restarts.
  always_ff @(posedge clk) begin
    if (state == FETCH && mem_req && mem_ack) begin
      line[{k, 4'b0000} +: 16] <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      base       <= '0;
      k          <= '0;
      tmo_cnt    <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      fill_valid <= 1'b0;
      fill_addr  <= '0;
      fill_data  <= '0;
      mem_err    <= 1'b0;
    end else begin
      fill_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (miss) begin
            base     <= pc_addr & ~ADDR_W'(7);
            mem_addr <= pc_addr & ~ADDR_W'(7);
            mem_req  <= 1'b1;
            k        <= '0;
            tmo_cnt  <= '0;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (!mem_req) begin
            // Reissue cycle after a timeout: same word, same address.
            mem_req <= 1'b1;
          end else if (mem_ack) begin
            tmo_cnt <= '0;
            if (k == 2'(LINE_WORDS - 1)) begin
              mem_req    <= 1'b0;
              fill_valid <= 1'b1;
              fill_addr  <= base;
              fill_data  <= {mem_rdata, line[LINE_W-17:0]};
              state      <= FILL;
            end else begin
              k        <= k + 2'd1;
              mem_addr <= base | ADDR_W'({k + 2'd1, 1'b0});
            end
          end else if (tmo_cnt == TW'(ACK_TIMEOUT - 1)) begin
            mem_req <= 1'b0;
            mem_err <= 1'b1;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        FILL:    state <= SETTLE;
        SETTLE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized bench for icache_refill_ctrl: a memory responder with selectable ack
// policies and a line/latency reference model derived from the refill rules.
module tb_icache_refill_ctrl;

  localparam int ACK_TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst, fetch_en, cache_hit, mem_ack;
  logic [15:0] pc_addr, mem_rdata, mem_addr, fill_addr;
  logic        stall, mem_req, fill_valid, mem_err;
  logic [63:0] fill_data;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] cur_base, cur_salt;
  bit          cur_ramp;
  bit          err_exp;
  logic [63:0] prev_data;
  logic [15:0] prev_addr;

  always #5 clk = ~clk;

  icache_refill_ctrl #(.ADDR_W(16), .LINE_WORDS(4), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc_addr(pc_addr), .cache_hit(cache_hit),
    .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .fill_valid(fill_valid), .fill_addr(fill_addr),
    .fill_data(fill_data), .mem_err(mem_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Instruction memory contents: a ramp inside the current line, or a salted hash.
  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    logic [15:0] off;
    off = (a - cur_base) >> 1;
    return cur_ramp ? (16'hA000 + off) : (cur_salt ^ (a * 16'h9E37));
  endfunction

  task automatic run_refill(input logic [15:0] pc, input int pol, input bit ramp, input bit chain,
                            output logic [63:0] got_data, output logic [15:0] got_addr,
                            output int got_stall, output int got_low, output int got_run);
    logic [63:0] exp_line;
    int words, w, wc, extra, hi_run, low_cnt, low_run, stall_cnt, fills;
    int bad_addr, bad_hold, bad_req, cyc, after_fill;
    bit fill_seen, done, a;
    cur_base = pc & 16'hFFF8;
    cur_ramp = ramp;
    cur_salt = 16'($urandom);
    for (int i = 0; i < 4; i++) exp_line[16*i +: 16] = mem_fn(cur_base + 16'(2*i));
    words = 0; w = 0; wc = 0; extra = 0; hi_run = 0; low_cnt = 0; low_run = 0;
    fills = 0; bad_addr = 0; bad_hold = 0; bad_req = 0; cyc = 0; after_fill = 0;
    fill_seen = 0; done = 0; got_data = '0; got_addr = '0;
    // miss cycle
    @(negedge clk);
    fetch_en = 1'b1; cache_hit = 1'b0; pc_addr = pc;
    mem_ack = (pol == 0); mem_rdata = mem_fn(mem_addr);
    #1;
    chk("miss_stall", 64'(stall), 64'd1);
    stall_cnt = stall ? 1 : 0;
    if (mem_req || fill_valid) bad_req++;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      fetch_en = 1'($urandom); cache_hit = 1'($urandom); pc_addr = 16'($urandom);
      case (pol)
        0:       a = 1'b1;
        1:       a = mem_req && (w == 2);
        2:       a = 1'($urandom);
        default: a = (words != 2) || (wc >= ACK_TIMEOUT + 5);
      endcase
      mem_ack = a;
      mem_rdata = mem_fn(mem_addr);
      #1;
      if (stall) stall_cnt++;
      if (fill_valid) begin
        fills++;
        if (!fill_seen) begin
          fill_seen = 1; got_data = fill_data; got_addr = fill_addr;
          if (words != 4) bad_req++;
        end
      end else if (!fill_seen) begin
        if (fill_data !== prev_data || fill_addr !== prev_addr) bad_hold++;
      end else if (fill_data !== got_data || fill_addr !== got_addr) begin
        bad_hold++;
      end
      if (fill_seen) begin
        if (mem_req) bad_req++;
        after_fill++;
        if (after_fill == 2) done = 1;
      end else if (words < 4) begin
        if (mem_req && mem_addr !== cur_base + 16'(2*words)) bad_addr++;
        if (mem_req && mem_ack) begin
          words++; w = 0; wc = 0; hi_run = 0;
        end else begin
          extra++; wc++;
          if (mem_req) begin
            w++; hi_run++;
          end else begin
            low_cnt++; low_run = hi_run; hi_run = 0;
          end
        end
      end else if (mem_req) begin
        bad_req++;
      end
    end
    chk("refill_done", 64'(done), 64'd1);
    if (!chain) begin
      @(negedge clk);
      fetch_en = 1'b0; cache_hit = 1'($urandom); mem_ack = 1'($urandom);
      mem_rdata = mem_fn(mem_addr);
      #1;
      chk("idle_stall", 64'(stall), 64'd0);
      chk("idle_req", 64'(mem_req), 64'd0);
      if (fill_valid) fills++;
      if (fill_data !== got_data || fill_addr !== got_addr) bad_hold++;
    end
    if (fill_seen) begin
      prev_data = got_data; prev_addr = got_addr;
    end
    chk("fill_pulses", 64'(fills), 64'd1);
    chk("fill_addr", 64'(got_addr), 64'(cur_base));
    chk("fill_data", got_data, exp_line);
    chk("stall_len", 64'(stall_cnt), 64'(7 + extra));
    chk("addr_seq", 64'(bad_addr), 64'd0);
    chk("fill_hold", 64'(bad_hold), 64'd0);
    chk("req_quiet", 64'(bad_req), 64'd0);
    chk("mem_err", 64'(mem_err), 64'(err_exp));
    got_stall = stall_cnt; got_low = low_cnt; got_run = low_run;
  endtask

  initial begin
    logic [63:0] d;
    logic [15:0] ad;
    int s, l, r, bad;
    rst = 1'b1; fetch_en = 1'b0; cache_hit = 1'b0; pc_addr = '0;
    mem_ack = 1'b0; mem_rdata = '0; err_exp = 0; prev_data = '0; prev_addr = '0;
    cur_base = '0; cur_ramp = 0; cur_salt = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_fill_valid", 64'(fill_valid), 64'd0);
    chk("rst_fill_addr", 64'(fill_addr), 64'd0);
    chk("rst_fill_data", fill_data, 64'd0);
    chk("rst_err", 64'(mem_err), 64'd0);
    chk("rst_stall_idle", 64'(stall), 64'd0);
    fetch_en = 1'b1; cache_hit = 1'b0; #1;
    chk("rst_stall_miss", 64'(stall), 64'd1);
    cache_hit = 1'b1; #1;
    chk("rst_stall_hit", 64'(stall), 64'd0);
    @(negedge clk);
    rst = 1'b0; fetch_en = 1'b0;

    // hit path and no-fetch path
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      fetch_en = (i < 12); cache_hit = (i < 12);
      pc_addr = 16'($urandom); mem_ack = 1'($urandom);
      #1;
      if (stall || mem_req || fill_valid) bad++;
    end
    chk("hit_path", 64'(bad), 64'd0);

    run_refill(16'h1236, 0, 1'b1, 1'b1, d, ad, s, l, r);
    chk("zw_data", d, 64'hA003A002A001A000);
    chk("zw_addr", 64'(ad), 64'h1230);
    chk("zw_stall", 64'(s), 64'd7);
    run_refill(16'h0046, 2, 1'b0, 1'b0, d, ad, s, l, r);
    chk("b2b_addr", 64'(ad), 64'h0040);

    run_refill(16'($urandom), 1, 1'b0, 1'b0, d, ad, s, l, r);
    chk("ws_stall", 64'(s), 64'd15);

    for (int i = 0; i < 6; i++)
      run_refill(16'($urandom), int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), d, ad, s, l, r);

    err_exp = 1;
    run_refill(16'($urandom), 3, 1'b0, 1'b0, d, ad, s, l, r);
    chk("to_low_cycles", 64'(l), 64'd1);
    chk("to_wait_run", 64'(r), 64'(ACK_TIMEOUT));
    run_refill(16'($urandom), 2, 1'b0, 1'b0, d, ad, s, l, r);

    // reset after two of four words
    cur_base = 16'h2468; cur_ramp = 0;
    @(negedge clk);
    fetch_en = 1'b1; cache_hit = 1'b0; pc_addr = 16'h2468; mem_ack = 1'b1; mem_rdata = mem_fn(mem_addr);
    @(negedge clk);
    fetch_en = 1'b0; mem_rdata = mem_fn(mem_addr);
    @(negedge clk);
    mem_rdata = mem_fn(mem_addr);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid_req", 64'(mem_req), 64'd0);
    chk("rstmid_addr", 64'(mem_addr), 64'd0);
    chk("rstmid_fill_valid", 64'(fill_valid), 64'd0);
    chk("rstmid_fill_data", fill_data, 64'd0);
    chk("rstmid_err", 64'(mem_err), 64'd0);
    chk("rstmid_stall", 64'(stall), 64'd0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mem_ack = 1'b1;
      #1;
      if (fill_valid || mem_req || stall) bad++;
    end
    chk("rstmid_no_fill", 64'(bad), 64'd0);
    err_exp = 0; prev_data = '0; prev_addr = '0;

    run_refill(16'($urandom), 0, 1'b0, 1'b0, d, ad, s, l, r);
    chk("post_rst_stall", 64'(s), 64'd7);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Miss-refill controller directly upstream of the instruction cache in the fetch stage.
- On a fetch miss it stalls the pipeline and reads the four 16-bit instruction words of the missing 64-bit line from instruction memory over a req/ack handshake.
- It assembles the line and presents it, with its line address, to the cache fill port for one cycle, then releases the stall once the cache can hit.

Parameters:
- ADDR_W, 16, byte-address width; matches the cache address port.
- LINE_WORDS, 4, 16-bit words per line. Fixed at 4; any other value is unsupported.
- ACK_TIMEOUT, 255, maximum cycles mem_req may wait for mem_ack before the word request is reissued.

Ports:
- clk, input, 1, system clock; all state updates on posedge.
- rst, input, 1, synchronous, active-high reset.
- fetch_en, input, 1, fetch stage is requesting an instruction this cycle.
- pc_addr, input, 16, byte address of the requested instruction.
- cache_hit, input, 1, hit flag from the cache for pc_addr.
- stall, output, 1, freeze PC and fetch stage.
- mem_req, output, 1, word read request to instruction memory.
- mem_addr, output, 16, byte address of the requested word.
- mem_ack, input, 1, memory returns mem_rdata this cycle.
- mem_rdata, input, 16, returned instruction word.
- fill_valid, output, 1, one-cycle pulse: fill_data/fill_addr valid for a cache write.
- fill_addr, output, 16, line base address {base[15:3],3'b000}.
- fill_data, output, 64, assembled line.
- mem_err, output, 1, sticky timeout flag.

Behaviour:
- Reset (rst=1 at posedge):
  - State returns to IDLE; word counter, timeout counter and retry state clear.
  - mem_req=0, mem_addr=0, fill_valid=0, fill_addr=0, fill_data=0, mem_err=0; stall follows the IDLE rule below.
  - Applies mid-refill: the partial line is discarded and no fill pulse is issued.
- States: IDLE, FETCH, FILL, SETTLE.
- IDLE:
  - Miss = fetch_en & ~cache_hit.
  - stall = miss, combinational.
  - On a miss: latch base = {pc_addr[15:3],3'b000}, clear word count k, go to FETCH.
- FETCH:
  - stall=1; mem_req=1; mem_addr = base + 2*k.
  - A transfer occurs on a posedge with mem_req & mem_ack. mem_rdata goes to line[16k+15:16k] (word k at base+2k, so word 0 lands in bits 15:0) and k increments.
  - mem_req stays high across consecutive words; the address updates on the same edge as the ack, so back-to-back acks take 4 cycles total.
  - After the 4th transfer, go to FILL.
  - mem_ack while mem_req=0 is ignored.
- Timeout:
  - A counter runs while mem_req=1 and mem_ack=0.
  - When it reaches ACK_TIMEOUT: set mem_err (sticky until rst), drop mem_req for exactly one cycle, then reissue the same word; k is unchanged.
  - The counter clears on every transfer and on every reissue.
- FILL:
  - stall=1; fill_valid=1 for exactly one cycle; fill_addr=base; fill_data=assembled line.
  - Go to SETTLE.
- SETTLE:
  - stall=1 for one cycle so the cache's registered hit reflects the new line; then go to IDLE.
- Output holding:
  - fill_data and fill_addr hold their last values until the next FILL; they must not toggle between fills.
- Latency:
  - Miss seen at cycle T.
  - FETCH occupies T+1..T+4 with zero-wait acks.
  - FILL at T+5, SETTLE at T+6, IDLE at T+7.
  - Minimum miss penalty is 7 stall cycles; each memory wait cycle adds one.
- Simultaneous events:
  - rst dominates everything.
  - fetch_en, pc_addr and cache_hit are ignored outside IDLE.
  - The mem_ack that lands on the final word and the FETCH->FILL transition happen on the same edge.

Test Plan:
- Reset mid-FETCH: assert rst after 2 of 4 acks -> next cycle IDLE, mem_req=0, fill_valid=0, fill_data=0, mem_err=0; no fill pulse follows.
- Zero-wait miss:
  - Stimulus: pc_addr=0x1236, fetch_en=1, cache_hit=0, mem_ack tied 1, mem_rdata=0xA000+word.
  - mem_addr steps 0x1230, 0x1232, 0x1234, 0x1236.
  - fill_valid pulses once with fill_addr=0x1230, fill_data=0xA003A002A001A000.
  - stall is high exactly 7 cycles.
- Wait states: memory acks every 3rd cycle -> fill_data correct, stall length is 7 + 8 = 15 cycles, mem_addr stable while waiting.
- Timeout: withhold mem_ack for word 2 for ACK_TIMEOUT+5 cycles -> mem_err=1, mem_req low for exactly one cycle, word 2 address reissued, line completes correctly, mem_err remains 1.
- Hit path: fetch_en=1, cache_hit=1 -> stall=0, mem_req never asserts. fetch_en=0 with cache_hit=0 -> no refill starts.
- Back-to-back misses: second miss to line 0x0040 immediately after SETTLE -> second fill_valid pulse with fill_addr=0x0040; first fill_data held unchanged until that FILL.
